// File: rtl/square_motion_ctrl.sv
// Per-frame square position/size sequencer. Switches are captured once per frame.
// The new origin, size and directions are committed to the outputs together in one edge.
module square_motion_ctrl #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int RESET_SIZE = 16
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        frame_start,
  input  logic [17:0] switches,
  output logic [9:0]  x_origin,
  output logic [9:0]  y_origin,
  output logic [9:0]  square_size,
  output logic        dir_x,
  output logic        dir_y,
  output logic        update_done
);
  typedef enum logic [2:0] {IDLE, LATCH, STEP_X, STEP_Y, COMMIT} state_t;

  localparam logic [10:0] HA = 11'(H_ACTIVE);
  localparam logic [10:0] VA = 11'(V_ACTIVE);
  localparam logic [9:0]  RS = 10'(RESET_SIZE);

  state_t      state_q;
  logic [3:0]  spd_x_q, spd_y_q;
  logic [9:0]  size_q;
  logic        recenter_q;
  logic [9:0]  wx_q, wy_q;
  logic        wdx_q, wdy_q;
  logic [9:0]  x_q, y_q, sq_q;
  logic        dx_q, dy_q, done_q;

  logic [9:0]  size_d, lim_x, lim_y;
  logic [10:0] x_d, y_d;

  // Returns {dir, pos}. Clamps first so a grown square never starts past its limit.
  function automatic logic [10:0] step_axis(input logic [9:0] pos, input logic [9:0] lim,
                                            input logic [3:0] s, input logic dir);
    logic [9:0]  p;
    logic [10:0] sum;
    logic [10:0] r;
    p   = (pos > lim) ? lim : pos;
    sum = {1'b0, p} + {7'd0, s};
    r   = {dir, p};
    if (s != 4'd0) begin
      if (dir) r = (sum >= {1'b0, lim}) ? {1'b0, lim} : {1'b1, sum[9:0]};
      else     r = (p <= {6'd0, s}) ? {1'b1, 10'd0} : {1'b0, p - {6'd0, s}};
    end
    return r;
  endfunction

  assign size_d = (switches[15:8] == 8'd0) ? 10'd1 : {2'b00, switches[15:8]};
  assign lim_x  = 10'(HA - {1'b0, size_q});
  assign lim_y  = 10'(VA - {1'b0, size_q});
  assign x_d    = recenter_q ? {1'b1, lim_x >> 1} : step_axis(wx_q, lim_x, spd_x_q, wdx_q);
  assign y_d    = recenter_q ? {1'b1, lim_y >> 1} : step_axis(wy_q, lim_y, spd_y_q, wdy_q);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      spd_x_q    <= '0;
      spd_y_q    <= '0;
      size_q     <= RS;
      recenter_q <= 1'b0;
      wx_q       <= '0;
      wy_q       <= '0;
      wdx_q      <= 1'b1;
      wdy_q      <= 1'b1;
      x_q        <= '0;
      y_q        <= '0;
      sq_q       <= RS;
      dx_q       <= 1'b1;
      dy_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (frame_start && switches[16]) state_q <= LATCH;
        LATCH: begin
          spd_x_q    <= switches[3:0];
          spd_y_q    <= switches[7:4];
          size_q     <= size_d;
          recenter_q <= switches[17];
          wx_q       <= x_q;
          wy_q       <= y_q;
          wdx_q      <= dx_q;
          wdy_q      <= dy_q;
          state_q    <= STEP_X;
        end
        STEP_X: begin
          {wdx_q, wx_q} <= x_d;
          state_q       <= STEP_Y;
        end
        // Y result goes straight to the outputs so the commit lands on the edge into COMMIT.
        STEP_Y: begin
          {wdy_q, wy_q} <= y_d;
          x_q     <= wx_q;
          dx_q    <= wdx_q;
          y_q     <= y_d[9:0];
          dy_q    <= y_d[10];
          sq_q    <= size_q;
          done_q  <= 1'b1;
          state_q <= COMMIT;
        end
        COMMIT:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign x_origin    = x_q;
  assign y_origin    = y_q;
  assign square_size = sq_q;
  assign dir_x       = dx_q;
  assign dir_y       = dy_q;
  assign update_done = done_q;
endmodule

// File: tb/tb_square_motion_ctrl.sv
// Directed bench for square_motion_ctrl: a behavioural model pushes expected commits
// to a scoreboard, and a negedge monitor pops and checks them when update_done fires.
module tb_square_motion_ctrl;
  logic        clock, resetn, frame_start;
  logic [17:0] switches;
  logic [9:0]  x_origin, y_origin, square_size;
  logic        dir_x, dir_y, update_done;

  square_motion_ctrl dut (
    .clock(clock), .resetn(resetn), .frame_start(frame_start), .switches(switches),
    .x_origin(x_origin), .y_origin(y_origin), .square_size(square_size),
    .dir_x(dir_x), .dir_y(dir_y), .update_done(update_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {int x; int y; int sz; bit dx; bit dy; int cyc;} exp_t;
  exp_t sb[$];

  int cyc = 0;
  int total = 0, passed = 0, fails = 0;
  int mx, my, msz;
  bit mdx, mdy;

  always @(posedge clock) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_axis(inout int p, inout bit d, input int spd, input int act,
                            input int sz, input bit rc);
    int lim;
    lim = act - sz;
    if (rc) begin
      p = lim / 2;
      d = 1'b1;
    end else begin
      if (p > lim) p = lim;
      if (spd != 0) begin
        if (d) begin
          if (p + spd >= lim) begin p = lim; d = 1'b0; end
          else p = p + spd;
        end else begin
          if (p <= spd) begin p = 0; d = 1'b1; end
          else p = p - spd;
        end
      end
    end
  endtask

  function automatic logic [17:0] mk(input bit rc, input bit run, input int sz,
                                     input int ys, input int xs);
    return {rc, run, 8'(sz), 4'(ys), 4'(xs)};
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; msz = 16; mdx = 1'b1; mdy = 1'b1;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".x"},    x_origin,    mx);
    chk({tag, ".y"},    y_origin,    my);
    chk({tag, ".size"}, square_size, msz);
    chk({tag, ".dx"},   dir_x,       mdx);
    chk({tag, ".dy"},   dir_y,       mdy);
  endtask

  // One accepted frame: model, push expectation, pulse, then let it drain.
  task automatic frame(input logic [17:0] sw);
    exp_t e;
    int sz;
    @(negedge clock);
    switches = sw;
    frame_start = 1'b1;
    sz = (sw[15:8] == 8'd0) ? 1 : int'(sw[15:8]);
    model_axis(mx, mdx, int'(sw[3:0]), 640, sz, sw[17]);
    model_axis(my, mdy, int'(sw[7:4]), 480, sz, sw[17]);
    msz = sz;
    e.x = mx; e.y = my; e.sz = msz; e.dx = mdx; e.dy = mdy; e.cyc = cyc;
    sb.push_back(e);
    @(negedge clock);
    frame_start = 1'b0;
    repeat (6) @(negedge clock);
    chk("drain", sb.size(), 0);
  endtask

  always @(negedge clock) begin
    if (update_done) begin
      if (sb.size() == 0) chk("spurious_update", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("upd.x",       x_origin,    e.x);
        chk("upd.y",       y_origin,    e.y);
        chk("upd.size",    square_size, e.sz);
        chk("upd.dx",      dir_x,       e.dx);
        chk("upd.dy",      dir_y,       e.dy);
        chk("upd.latency", cyc,         e.cyc + 4);
      end
    end
  end

  initial begin
    resetn = 1'b0; frame_start = 1'b0; switches = '0;
    model_reset();
    repeat (3) @(negedge clock);
    check_outs("reset");
    chk("reset.done", update_done, 0);
    resetn = 1'b1;
    repeat (20) @(negedge clock);
    check_outs("idle_hold");

    frame(mk(0, 1, 16, 2, 4));
    chk("first.x", x_origin, 4);
    chk("first.y", y_origin, 2);
    repeat (9) frame(mk(0, 1, 16, 2, 4));
    chk("ten.x", x_origin, 40);
    chk("ten.y", y_origin, 20);

    // Right edge bounce
    frame(mk(1, 1, 16, 0, 0));
    chk("rc16.x", x_origin, 312);
    chk("rc16.y", y_origin, 232);
    repeat (77) frame(mk(0, 1, 16, 0, 4));
    chk("pre_r.x", x_origin, 620);
    frame(mk(0, 1, 16, 0, 8));
    chk("bounce_r.x", x_origin, 624);
    chk("bounce_r.dx", dir_x, 0);
    frame(mk(0, 1, 16, 0, 8));
    chk("after_r.x", x_origin, 616);

    // Bottom edge bounce
    frame(mk(1, 1, 16, 0, 0));
    repeat (57) frame(mk(0, 1, 16, 4, 0));
    chk("pre_b.y", y_origin, 460);
    frame(mk(0, 1, 16, 8, 0));
    chk("bounce_b.y", y_origin, 464);
    chk("bounce_b.dy", dir_y, 0);
    frame(mk(0, 1, 16, 8, 0));
    chk("after_b.y", y_origin, 456);

    // Left edge bounce and zero speed
    frame(mk(1, 1, 16, 0, 0));
    repeat (24) frame(mk(0, 1, 16, 0, 13));
    chk("top13.x", x_origin, 624);
    repeat (47) frame(mk(0, 1, 16, 0, 13));
    chk("down13.x", x_origin, 13);
    frame(mk(0, 1, 16, 0, 5));
    frame(mk(0, 1, 16, 0, 5));
    chk("pre_l.x", x_origin, 3);
    chk("pre_l.dx", dir_x, 0);
    frame(mk(0, 1, 16, 0, 5));
    chk("bounce_l.x", x_origin, 0);
    chk("bounce_l.dx", dir_x, 1);
    frame(mk(0, 1, 16, 0, 0));
    chk("zero.x", x_origin, 0);
    chk("zero.dx", dir_x, 1);

    // Recenter with size 0 and 32
    frame(mk(1, 1, 0, 3, 3));
    chk("rc0.size", square_size, 1);
    chk("rc0.x", x_origin, 319);
    chk("rc0.y", y_origin, 239);
    frame(mk(1, 1, 32, 3, 3));
    chk("rc32.x", x_origin, 304);
    chk("rc32.y", y_origin, 224);
    chk("rc32.dirs", {dir_x, dir_y}, 2'b11);

    // Run off: frame_start ignored
    @(negedge clock);
    switches = mk(0, 0, 16, 3, 3);
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
    repeat (8) @(negedge clock);
    check_outs("run_off");

    // Second frame_start at N+2 dropped; switch change after LATCH ignored
    begin
      exp_t e;
      @(negedge clock);
      switches = mk(0, 1, 32, 1, 2);
      frame_start = 1'b1;
      model_axis(mx, mdx, 2, 640, 32, 1'b0);
      model_axis(my, mdy, 1, 480, 32, 1'b0);
      msz = 32;
      e.x = mx; e.y = my; e.sz = msz; e.dx = mdx; e.dy = mdy; e.cyc = cyc;
      sb.push_back(e);
      @(negedge clock);
      frame_start = 1'b0;
      @(negedge clock);
      frame_start = 1'b1;
      switches = mk(1, 1, 99, 15, 15);
      @(negedge clock);
      frame_start = 1'b0;
      repeat (10) @(negedge clock);
      chk("double.drain", sb.size(), 0);
      check_outs("double");
    end

    // Reset asserted mid-sequence
    @(negedge clock);
    switches = mk(0, 1, 16, 5, 5);
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
    @(negedge clock);
    resetn = 1'b0;
    #1;
    model_reset();
    check_outs("midreset");
    chk("midreset.done", update_done, 0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (10) @(negedge clock);
    check_outs("post_reset");
    chk("final.drain", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running, want done");
    $fatal(1, "timeout");
  end
endmodule
